audio_soft_mute: RTL and testbench

Click-free mute stage for the audio AGC path. It sits directly downstream of the 1-bit Nios II PIO mute register: its `mute_req` input is driven by that PIO's `out_port`. It scales the streaming audio samples by a gain that ramps linearly between unity and zero whenever `mute_req` changes, so software mute and unmute never produce a step in the waveform. Status outputs (`muted`, `busy`) are intended for a PIO input port so firmware can poll ramp completion.

---
 rtl/audio_soft_mute.sv | 133 +++++++++++++
 tb/tb_audio_soft_mute.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_soft_mute.sv
// Click-free soft mute: scales a signed sample stream by a gain that ramps
// linearly between unity (256) and zero whenever the mute request changes.
module audio_soft_mute #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned RAMP_STEP = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mute_req,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     muted,
    output logic                     busy
);

    localparam int unsigned GAIN_W = 9;
    localparam int unsigned SUM_W  = GAIN_W + 1;
    localparam int unsigned PROD_W = DATA_W + 10;
    localparam int unsigned FRAC_W = 8;

    localparam logic [GAIN_W-1:0] GAIN_ZERO  = GAIN_W'(0);
    localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(256);
    localparam logic [GAIN_W-1:0] GAIN_STEP  = GAIN_W'(RAMP_STEP);

    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_DOWN = 2'd1,
        ST_MUTE = 2'd2,
        ST_UP   = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [GAIN_W-1:0]         gain;
    logic [GAIN_W-1:0]         gain_next;
    logic [GAIN_W-1:0]         gain_dec;
    logic [GAIN_W-1:0]         gain_inc;
    logic [SUM_W-1:0]          gain_sum;
    logic signed [PROD_W-1:0]  data_ext;
    logic signed [PROD_W-1:0]  gain_ext;
    logic signed [PROD_W-1:0]  product;
    logic signed [DATA_W-1:0]  scaled;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_MUTE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; runs every clock, independent of in_valid
    always_comb begin
        state_next = state;
        unique case (state)
            ST_PASS: begin
                if (mute_req) begin
                    state_next = ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (gain == GAIN_ZERO) begin
                    state_next = ST_MUTE;
                end else if (!mute_req) begin
                    state_next = ST_UP;
                end
            end
            ST_MUTE: begin
                if (!mute_req) begin
                    state_next = ST_UP;
                end
            end
            ST_UP: begin
                if (gain == GAIN_UNITY) begin
                    state_next = ST_PASS;
                end else if (mute_req) begin
                    state_next = ST_DOWN;
                end
            end
            default: state_next = ST_MUTE;
        endcase
    end

    // Saturating ramp arithmetic, clamped to 0..256
    always_comb begin
        gain_sum = SUM_W'(gain) + SUM_W'(GAIN_STEP);
        gain_dec = (gain <= GAIN_STEP) ? GAIN_ZERO : (gain - GAIN_STEP);
        gain_inc = (gain_sum >= SUM_W'(GAIN_UNITY)) ? GAIN_UNITY : GAIN_W'(gain_sum);
    end

    // Gain moves only on accepted samples, steered by the registered state
    always_comb begin
        gain_next = gain;
        if (in_valid) begin
            unique case (state)
                ST_DOWN: gain_next = gain_dec;
                ST_UP:   gain_next = gain_inc;
                default: gain_next = gain;
            endcase
        end
    end

    // Signed sample times zero-extended gain, then floor divide by 256
    always_comb begin
        data_ext = PROD_W'(in_data);
        gain_ext = $signed(PROD_W'(gain));
        product  = data_ext * gain_ext;
        scaled   = DATA_W'(product >>> FRAC_W);
    end

    // Gain, output sample and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            gain      <= GAIN_ZERO;
            out_valid <= 1'b0;
            out_data  <= '0;
            muted     <= 1'b1;
            busy      <= 1'b0;
        end else begin
            gain      <= gain_next;
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= scaled;
            end
            muted <= (state_next == ST_MUTE);
            busy  <= (state_next == ST_DOWN) || (state_next == ST_UP);
        end
    end

endmodule

// File: tb/tb_audio_soft_mute.sv
// Directed bench for audio_soft_mute: fade-in, truncation, reversal,
// gapped input, reset mid-ramp and the single-step ramp corner.
module tb_audio_soft_mute;

    localparam int unsigned DW = 16;

    logic                 clk;
    logic                 reset;
    logic                 mute_req;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 muted;
    logic                 busy;

    logic                 f_mute_req;
    logic                 f_in_valid;
    logic signed [DW-1:0] f_in_data;
    logic                 f_out_valid;
    logic signed [DW-1:0] f_out_data;
    logic                 f_muted;
    logic                 f_busy;

    int n_vec;
    int n_err;
    int exp_v;

    audio_soft_mute #(.DATA_W(DW), .RAMP_STEP(4)) u_dut (
        .clk(clk), .reset(reset), .mute_req(mute_req),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .muted(muted), .busy(busy)
    );

    audio_soft_mute #(.DATA_W(DW), .RAMP_STEP(256)) u_fast (
        .clk(clk), .reset(reset), .mute_req(f_mute_req),
        .in_valid(f_in_valid), .in_data(f_in_data),
        .out_valid(f_out_valid), .out_data(f_out_data),
        .muted(f_muted), .busy(f_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic feed(input int n, input int d);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(d);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got %0d expected %0d", 0, 1);
        $fatal(1, "timeout");
    end

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        mute_req   = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        f_mute_req = 1'b0;
        f_in_valid = 1'b0;
        f_in_data  = '0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        chk("rst_muted", int'(muted), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);

        // power-up fade-in: one clock to leave MUTE, then samples in UP
        idle();
        chk("fade_muted_fall", int'(muted), 0);
        chk("fade_busy_rise", int'(busy), 1);
        for (int k = 0; k <= 64; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(1000);
            tick();
            exp_v = (k < 64) ? (4000 * k) / 256 : 1000;
            chk("fade_valid", int'(out_valid), 1);
            chk("fade_data", int'(out_data), exp_v);
            if (k == 0)  chk("fade_out1", int'(out_data), 0);
            if (k == 1)  chk("fade_out2", int'(out_data), 15);
            if (k == 2)  chk("fade_out3", int'(out_data), 31);
            if (k == 3)  chk("fade_out4", int'(out_data), 46);
            if (k == 63) chk("fade_out64", int'(out_data), 984);
            if (k == 63) chk("fade_busy_at_unity", int'(busy), 1);
        end
        chk("fade_busy_fall", int'(busy), 0);
        chk("fade_muted", int'(muted), 0);

        // mute with negative samples: floor rounding toward -inf
        mute_req = 1'b1;
        idle();
        chk("neg_busy", int'(busy), 1);
        chk("neg_hold_valid", int'(out_valid), 0);
        chk("neg_hold_data", int'(out_data), 1000);
        for (int k = 0; k <= 64; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(-1000);
            tick();
            exp_v = (-1000 * (256 - 4 * k)) >>> 8;
            chk("neg_data", int'(out_data), exp_v);
            if (k == 0)  chk("neg_first", int'(out_data), -1000);
            if (k == 1)  chk("neg_second", int'(out_data), -985);
            if (k == 63) chk("neg_last_nonzero", int'(out_data), -16);
            if (k == 64) chk("neg_settle", int'(out_data), 0);
        end
        chk("neg_muted", int'(muted), 1);
        chk("neg_busy_end", int'(busy), 0);

        // mid-ramp reversal at g=128; in_data=256 makes out_data equal g
        mute_req = 1'b0;
        idle();
        feed(64, 0);
        idle();
        chk("rev_pass0", int'(busy), 0);
        mute_req = 1'b1;
        idle();
        feed(32, 256);
        mute_req = 1'b0;
        idle();
        chk("rev_busy", int'(busy), 1);
        for (int k = 0; k < 32; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(256);
            tick();
            chk("rev_gain", int'(out_data), 128 + 4 * k);
        end
        idle();
        chk("rev_pass_busy", int'(busy), 0);
        chk("rev_pass_muted", int'(muted), 0);
        chk("rev_hold_valid", int'(out_valid), 0);
        chk("rev_hold_data", int'(out_data), 252);

        // gapped input in UP: one pulse every 5th clock
        mute_req = 1'b1;
        idle();
        feed(64, 0);
        idle();
        chk("gap_muted", int'(muted), 1);
        mute_req = 1'b0;
        idle();
        for (int p = 0; p < 8; p++) begin
            in_valid = 1'b1;
            in_data  = 16'(256);
            tick();
            chk("gap_valid", int'(out_valid), 1);
            chk("gap_gain", int'(out_data), 4 * p);
            in_valid = 1'b0;
            for (int j = 0; j < 4; j++) begin
                tick();
                chk("gap_no_valid", int'(out_valid), 0);
                chk("gap_busy", int'(busy), 1);
            end
        end
        chk("gap_hold_data", int'(out_data), 28);

        // reset while DOWN at g=100, with a sample in flight
        feed(56, 0);
        idle();
        mute_req = 1'b1;
        idle();
        feed(38, 0);
        in_valid = 1'b1;
        in_data  = 16'(256);
        tick();
        chk("mid_gain_104", int'(out_data), 104);
        reset    = 1'b1;
        in_data  = 16'(1000);
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_data", int'(out_data), 0);
        chk("mid_rst_muted", int'(muted), 1);
        chk("mid_rst_busy", int'(busy), 0);
        in_valid = 1'b1;
        in_data  = 16'(256);
        tick();
        in_valid = 1'b0;
        chk("mid_rst_gain", int'(out_data), 0);
        chk("mid_rst_valid2", int'(out_valid), 1);
        chk("mid_rst_muted2", int'(muted), 1);

        // RAMP_STEP=256: left MUTE one clock after reset, now UP at g=0
        f_in_valid = 1'b1;
        f_in_data  = 16'(1000);
        tick();
        chk("fast_unmute_0", int'(f_out_data), 0);
        tick();
        chk("fast_unmute_1", int'(f_out_data), 1000);
        f_in_valid = 1'b0;
        tick();
        chk("fast_pass", int'(f_busy), 0);
        f_mute_req = 1'b1;
        tick();
        chk("fast_down", int'(f_busy), 1);
        f_in_valid = 1'b1;
        tick();
        chk("fast_mute_0", int'(f_out_data), 1000);
        tick();
        chk("fast_mute_1", int'(f_out_data), 0);
        chk("fast_muted", int'(f_muted), 1);
        tick();
        chk("fast_mute_2", int'(f_out_data), 0);
        f_in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
